// File: rtl/regfile_write_arbiter_if.sv
// Write-request bundle for the two requesters that share the Register_File write port.
// master: the requester side (core writeback / debug loader); slave: the arbiter.
interface regfile_write_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  a_valid;
  logic                  a_ready;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  b_valid;
  logic                  b_ready;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_data;

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Owner of the Register_File write port. After reset it sweeps x1..xN with INIT_VALUE,
// then round-robin arbitrates between port A (writeback) and port B (debug/loader).
// Writes to x0 complete the handshake but never raise WE3.
module regfile_write_arbiter #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_write_arbiter_if.slave bus,
  output logic                  WE3,
  output logic [ADDR_WIDTH-1:0] WA3,
  output logic [DATA_WIDTH-1:0] WD3,
  output logic                  init_done
);

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;

  localparam logic PTR_A = 1'b0;
  localparam logic PTR_B = 1'b1;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_ptr;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_wa;
  logic [DATA_WIDTH-1:0] r_wd;
  logic                  r_init_done;

  logic w_run;
  logic w_grant_a;
  logic w_grant_b;

  // Grant decode: single requester wins outright, contention resolved by the pointer.
  always_comb begin
    w_run     = (r_state == ST_RUN);
    w_grant_a = w_run && bus.a_valid && (!bus.b_valid || (r_ptr == PTR_A));
    w_grant_b = w_run && bus.b_valid && (!bus.a_valid || (r_ptr == PTR_B));
  end

  assign bus.a_ready = w_grant_a;
  assign bus.b_ready = w_grant_b;

  assign WE3       = r_we;
  assign WA3       = r_wa;
  assign WD3       = r_wd;
  assign init_done = r_init_done;

  // Init sweep, then registered write-port drive from the granted requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_cnt       <= ADDR_WIDTH'(1);
      r_ptr       <= PTR_A;
      r_we        <= 1'b0;
      r_wa        <= '0;
      r_wd        <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          // Leave INIT only once the last register's write has been on the port,
          // so no request is accepted while the sweep is still visible.
          if (r_we && (r_wa == '1)) begin
            r_state     <= ST_RUN;
            r_we        <= 1'b0;
            r_init_done <= 1'b1;
          end else begin
            r_we  <= 1'b1;
            r_wa  <= r_cnt;
            r_wd  <= INIT_VALUE;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          r_we <= 1'b0;
          if (w_grant_a) begin
            r_ptr <= PTR_B;
            if (bus.a_addr != '0) begin
              r_we <= 1'b1;
              r_wa <= bus.a_addr;
              r_wd <= bus.a_data;
            end
          end else if (w_grant_b) begin
            r_ptr <= PTR_A;
            if (bus.b_addr != '0) begin
              r_we <= 1'b1;
              r_wa <= bus.b_addr;
              r_wd <= bus.b_data;
            end
          end
        end
        default: begin
          r_state     <= ST_INIT;
          r_cnt       <= ADDR_WIDTH'(1);
          r_ptr       <= PTR_A;
          r_we        <= 1'b0;
          r_init_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
